data_tx_packetizer: RTL and testbench

- Transmit-side packetizer for the photonic data plane. It buffers 16-bit payload words written by the GPP, then emits one 32-bit packet per word toward the interconnect link, using a valid/ready handshake.
- Packet format is {dest_node_id, payload}, which is the format a remote node's receive path consumes. The block signals the end of each message with a last marker and a completion pulse.

---
 rtl/data_plane_pkg.sv | 20 ++
 rtl/tx_word_buffer.sv | 24 ++
 rtl/data_tx_packetizer.sv | 109 ++++++++++
 tb/tb_data_tx_packetizer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_plane_pkg.sv
// Shared widths, transmit FSM states and the packet packing helper for the photonic data plane.
package data_plane_pkg;

  localparam int PKT_W     = 32;
  localparam int NODE_ID_W = 16;
  localparam int WORD_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

  // Remote receive paths expect the destination in the upper half.
  function automatic logic [PKT_W-1:0] make_packet(input logic [NODE_ID_W-1:0] node,
                                                   input logic [WORD_W-1:0]    word);
    return {node, word};
  endfunction

endpackage

// File: rtl/tx_word_buffer.sv
// Payload store for the transmit packetizer: one synchronous write port, one asynchronous read port.
module tx_word_buffer
  import data_plane_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_tx_packetizer.sv
// Buffers GPP payload words, then streams {dest, payload} packets to the link over valid/ready.
module data_tx_packetizer
  import data_plane_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NODE_ID_W-1:0]      dest_node_id,
  input  logic                      gpp_tx_signal,
  input  logic [WORD_W-1:0]         gpp_tx_data,
  input  logic                      gpp_tx_start,
  input  logic                      link_ready,
  output logic                      data_tx_flag,
  output logic [PKT_W-1:0]          data_tx_packet,
  output logic                      data_tx_last,
  output logic                      data_tx_complete_flag,
  output logic [WORD_W-1:0]         RAM_tx_data_out,
  output logic [$clog2(DEPTH):0]    sp_tx_current,
  output logic                      tx_busy,
  output logic                      buf_full
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  tx_state_t             state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NODE_ID_W-1:0]  dest_q, dest_d;
  logic [CNT_W-1:0]      eff_cnt;
  logic                  wr_en;
  logic [WORD_W-1:0]     rd_word;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    wr_en    = 1'b0;
    eff_cnt  = cnt_q;
    case (state_q)
      IDLE: begin
        wr_en   = gpp_tx_signal && (cnt_q != FULL_CNT);
        eff_cnt = cnt_q + CNT_W'(wr_en);
        cnt_d   = eff_cnt;
        if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        // A word written alongside start belongs to the message.
        if (gpp_tx_start && (eff_cnt != '0)) begin
          dest_d  = dest_node_id;
          state_d = SEND;
        end
      end
      SEND: begin
        if (link_ready) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q - CNT_W'(1);
          // Rewind both pointers so the buffer is empty-at-zero in DONE.
          if (cnt_q == CNT_W'(1)) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
    end
  end

  tx_word_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en && rst),
    .wr_addr (wr_ptr_q),
    .wr_data (gpp_tx_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  // Packet is forced to zero outside SEND so stale buffer contents never leak out.
  assign data_tx_packet        = (state_q == SEND) ? make_packet(dest_q, rd_word) : '0;
  assign RAM_tx_data_out       = data_tx_packet[WORD_W-1:0];
  assign data_tx_flag          = (state_q == SEND);
  assign data_tx_last          = (state_q == SEND) && (cnt_q == CNT_W'(1));
  assign data_tx_complete_flag = (state_q == DONE);
  assign tx_busy               = (state_q != IDLE);
  assign buf_full              = (cnt_q == FULL_CNT);
  assign sp_tx_current         = cnt_q;

endmodule

// File: tb/tb_data_tx_packetizer.sv
// Bench for data_tx_packetizer: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_data_tx_packetizer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dest_node_id;
  logic        gpp_tx_signal;
  logic [15:0] gpp_tx_data;
  logic        gpp_tx_start;
  logic        link_ready;
  logic        data_tx_flag;
  logic [31:0] data_tx_packet;
  logic        data_tx_last;
  logic        data_tx_complete_flag;
  logic [15:0] RAM_tx_data_out;
  logic [4:0]  sp_tx_current;
  logic        tx_busy;
  logic        buf_full;

  data_tx_packetizer #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dest_node_id          (dest_node_id),
    .gpp_tx_signal         (gpp_tx_signal),
    .gpp_tx_data           (gpp_tx_data),
    .gpp_tx_start          (gpp_tx_start),
    .link_ready            (link_ready),
    .data_tx_flag          (data_tx_flag),
    .data_tx_packet        (data_tx_packet),
    .data_tx_last          (data_tx_last),
    .data_tx_complete_flag (data_tx_complete_flag),
    .RAM_tx_data_out       (RAM_tx_data_out),
    .sp_tx_current         (sp_tx_current),
    .tx_busy               (tx_busy),
    .buf_full              (buf_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: message held as a queue of words.
  logic [15:0] mq[$];
  bit          m_send, m_done;
  logic [15:0] m_dest;

  typedef struct {
    bit r, s, st, rdy;
    logic [15:0] d, dst;
    bit f, l, c, b, fu;
    logic [31:0] p;
    logic [4:0]  sp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, a, e);
    end
  endtask

  task automatic drive(input bit r, input bit s, input logic [15:0] d, input bit st,
                       input logic [15:0] dst, input bit rdy);
    rst = r; gpp_tx_signal = s; gpp_tx_data = d; gpp_tx_start = st;
    dest_node_id = dst; link_ready = rdy;
  endtask

  task automatic m_edge();
    if (!rst) begin
      mq.delete(); m_send = 0; m_done = 0; m_dest = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_send) begin
      if (link_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin m_send = 0; m_done = 1; end
      end
    end else begin
      if (gpp_tx_signal && mq.size() < DEPTH) mq.push_back(gpp_tx_data);
      if (gpp_tx_start && mq.size() > 0) begin m_send = 1; m_dest = dest_node_id; end
    end
  endtask

  task automatic cmp_model();
    logic [31:0] ep;
    ep = m_send ? {m_dest, mq[0]} : 32'h0;
    chk("m_flag", 32'(data_tx_flag), 32'(m_send));
    chk("m_pkt", data_tx_packet, ep);
    chk("m_ram", 32'(RAM_tx_data_out), 32'(ep[15:0]));
    chk("m_last", 32'(data_tx_last), 32'(m_send && mq.size() == 1));
    chk("m_cmp", 32'(data_tx_complete_flag), 32'(m_done));
    chk("m_sp", 32'(sp_tx_current), 32'(mq.size()));
    chk("m_busy", 32'(tx_busy), 32'(m_send || m_done));
    chk("m_full", 32'(buf_full), 32'(mq.size() == DEPTH));
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic add(input bit r, input bit s, input logic [15:0] d, input bit st,
                     input logic [15:0] dst, input bit rdy, input bit f, input logic [31:0] p,
                     input bit l, input bit c, input logic [4:0] sp, input bit b, input bit fu);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.st = st; v.dst = dst; v.rdy = rdy;
    v.f = f; v.p = p; v.l = l; v.c = c; v.sp = sp; v.b = b; v.fu = fu;
    vecs.push_back(v);
  endtask

  initial begin
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    m_send = 0; m_done = 0; m_dest = '0;

    // Reset, basic 3-word message, then the same message with link back-pressure.
    add(0,0,16'h0,0,16'h0,0, 0,32'h0,0,0,5'd0,0,0);
    add(0,0,16'h0,0,16'h0,0, 0,32'h0,0,0,5'd0,0,0);
    add(1,1,16'h1111,0,16'h0,0, 0,32'h0,0,0,5'd1,0,0);
    add(1,1,16'h2222,0,16'h0,0, 0,32'h0,0,0,5'd2,0,0);
    add(1,1,16'h3333,0,16'h0,0, 0,32'h0,0,0,5'd3,0,0);
    add(1,0,16'h0,1,16'h0005,1, 1,32'h00051111,0,0,5'd3,1,0);
    add(1,0,16'h0,0,16'h0,1, 1,32'h00052222,0,0,5'd2,1,0);
    add(1,0,16'h0,0,16'h0,1, 1,32'h00053333,1,0,5'd1,1,0);
    add(1,0,16'h0,0,16'h0,1, 0,32'h0,0,1,5'd0,1,0);
    add(1,0,16'h0,0,16'h0,0, 0,32'h0,0,0,5'd0,0,0);
    add(1,1,16'h1111,0,16'h0,0, 0,32'h0,0,0,5'd1,0,0);
    add(1,1,16'h2222,0,16'h0,0, 0,32'h0,0,0,5'd2,0,0);
    add(1,1,16'h3333,0,16'h0,0, 0,32'h0,0,0,5'd3,0,0);
    add(1,0,16'h0,1,16'h0005,0, 1,32'h00051111,0,0,5'd3,1,0);
    add(1,0,16'h0,0,16'h0,1, 1,32'h00052222,0,0,5'd2,1,0);
    add(1,0,16'h0,0,16'h0,0, 1,32'h00052222,0,0,5'd2,1,0);
    add(1,0,16'h0,0,16'h0,0, 1,32'h00052222,0,0,5'd2,1,0);
    add(1,0,16'h0,0,16'h0,1, 1,32'h00053333,1,0,5'd1,1,0);
    add(1,0,16'h0,0,16'h0,1, 0,32'h0,0,1,5'd0,1,0);
    add(1,0,16'h0,0,16'h0,0, 0,32'h0,0,0,5'd0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].st, vecs[i].dst, vecs[i].rdy);
      step();
      chk($sformatf("v%0d_flag", i), 32'(data_tx_flag), 32'(vecs[i].f));
      chk($sformatf("v%0d_pkt", i), data_tx_packet, vecs[i].p);
      chk($sformatf("v%0d_ram", i), 32'(RAM_tx_data_out), 32'(vecs[i].p[15:0]));
      chk($sformatf("v%0d_last", i), 32'(data_tx_last), 32'(vecs[i].l));
      chk($sformatf("v%0d_cmp", i), 32'(data_tx_complete_flag), 32'(vecs[i].c));
      chk($sformatf("v%0d_sp", i), 32'(sp_tx_current), 32'(vecs[i].sp));
      chk($sformatf("v%0d_busy", i), 32'(tx_busy), 32'(vecs[i].b));
      chk($sformatf("v%0d_full", i), 32'(buf_full), 32'(vecs[i].fu));
    end

    // Overfill: the 17th word must be dropped.
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 16'(i), 0, 16'h0, 0);
      step();
      if (i == 14) chk("full_at15", 32'(buf_full), 32'd0);
      if (i >= 15) begin
        chk("full_set", 32'(buf_full), 32'd1);
        chk("full_sp", 32'(sp_tx_current), 32'd16);
      end
    end
    drive(1, 0, 16'h0, 1, 16'h0003, 1);
    step();
    drive(1, 0, 16'h0, 0, 16'h0, 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_pkt", data_tx_packet, {16'h0003, 16'(i)});
      chk("ovf_last", 32'(data_tx_last), 32'(i == 15));
      step();
    end
    chk("ovf_cmp", 32'(data_tx_complete_flag), 32'd1);
    drive(1, 0, 16'h0, 0, 16'h0, 0);
    step();

    // Start on an empty buffer is ignored; start with a same-cycle write is not.
    drive(1, 0, 16'h0, 1, 16'h0077, 1);
    step();
    chk("empty_flag", 32'(data_tx_flag), 32'd0);
    step();
    chk("empty_cmp", 32'(data_tx_complete_flag), 32'd0);
    drive(1, 1, 16'hABCD, 1, 16'h0077, 0);
    step();
    chk("wst_pkt", data_tx_packet, 32'h0077ABCD);
    chk("wst_last", 32'(data_tx_last), 32'd1);
    drive(1, 0, 16'h0, 0, 16'h0, 1);
    step();
    chk("wst_cmp", 32'(data_tx_complete_flag), 32'd1);
    step();

    // Reset after the first transfer aborts without a complete pulse.
    drive(1, 1, 16'hAAA1, 0, 16'h0, 0); step();
    drive(1, 1, 16'hAAA2, 0, 16'h0, 0); step();
    drive(1, 1, 16'hAAA3, 0, 16'h0, 0); step();
    drive(1, 0, 16'h0, 1, 16'h0006, 1); step();
    drive(1, 0, 16'h0, 0, 16'h0, 1); step();
    chk("abort_pre", data_tx_packet, 32'h0006AAA2);
    drive(0, 0, 16'h0, 0, 16'h0, 1); step();
    chk("abort_pkt", data_tx_packet, 32'h0);
    chk("abort_cmp", 32'(data_tx_complete_flag), 32'd0);
    chk("abort_sp", 32'(sp_tx_current), 32'd0);
    drive(1, 0, 16'h0, 0, 16'h0, 0); step();
    chk("abort_cmp2", 32'(data_tx_complete_flag), 32'd0);
    drive(1, 1, 16'h4242, 1, 16'h0009, 0); step();
    chk("post_pkt", data_tx_packet, 32'h00094242);
    chk("post_last", 32'(data_tx_last), 32'd1);
    drive(1, 0, 16'h0, 0, 16'h0, 1); step();
    chk("post_cmp", 32'(data_tx_complete_flag), 32'd1);

    // Random traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, 16'($urandom),
            $urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 2) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
